// File: rtl/uart_rx.sv
// UART 8N1 receiver: double-flop synchronizer, mid-bit sampling, ready/clear handshake,
// framing (stop bit low) and overrun (byte lands while previous one unread) reporting.
module uart_rx #(
  parameter int unsigned BAUD_DIV = 2604,
  parameter int unsigned HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       busy,
  output logic       frm_err,
  output logic       ovr_err
);

  localparam int unsigned CntW = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] BaudReload = CntW'(BAUD_DIV - 1);
  localparam logic [CntW-1:0] HalfReload = CntW'(HALF_DIV - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          state_q, state_d;
  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rdy_q, rdy_d;
  logic            busy_q, busy_d;
  logic            frm_q, frm_d;
  logic            ovr_q, ovr_d;
  logic            sample;
  logic            commit;

  assign sample = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    rdy_d     = rdy_q;
    ovr_d     = ovr_q;
    frm_d     = 1'b0;
    commit    = 1'b0;

    case (state_q)
      StIdle: begin
        if (rx_prev_q && !rx_s2_q) begin
          state_d = StStart;
          cnt_d   = HalfReload;
        end
      end
      StStart: begin
        if (!sample) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (rx_s2_q) begin
          state_d = StIdle;  // start bit gone by mid-bit: treat as glitch
        end else begin
          state_d  = StData;
          cnt_d    = BaudReload;
          bitcnt_d = 4'd0;
        end
      end
      StData: begin
        if (!sample) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          shift_d  = {rx_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          cnt_d    = BaudReload;
          if (bitcnt_q == 4'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (!sample) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (rx_s2_q) begin
          commit  = 1'b1;
          state_d = StIdle;
        end else begin
          frm_d   = 1'b1;
          state_d = StBreak;
        end
      end
      StBreak: begin
        if (rx_s2_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A commit beats a simultaneous clear; the clear still suppresses the overrun flag.
    if (commit) begin
      rx_data_d = shift_q;
      rdy_d     = 1'b1;
      ovr_d     = clr_rdy ? 1'b0 : (ovr_q | rdy_q);
    end else if (clr_rdy) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      bitcnt_q  <= 4'd0;
      shift_q   <= 8'h00;
      rx_data_q <= 8'h00;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      frm_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_s1_q   <= RX;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      frm_q     <= frm_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;
  assign busy    = busy_q;
  assign frm_err = frm_q;
  assign ovr_err = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a small baud divisor; expected bytes go through a queue.
module tb_uart_rx;

  localparam int BD  = 32;
  localparam int HD  = BD / 2;
  localparam int LAT = 2 + HD + 9 * BD + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RX = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy, busy, frm_err, ovr_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int busy_rise_cyc = 0, busy_fall_cyc = 0, rdy_rise_cyc = 0, frm_rise_cyc = 0;
  int frm_cnt = 0;
  int frm_base;
  logic busy_prev = 1'b0, rdy_prev = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] a5 = 8'hA5;

  uart_rx #(.BAUD_DIV(BD), .HALF_DIV(HD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .busy    (busy),
    .frm_err (frm_err),
    .ovr_err (ovr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy && !busy_prev) busy_rise_cyc <= cyc;
    if (!busy && busy_prev) busy_fall_cyc <= cyc;
    if (rdy && !rdy_prev) rdy_rise_cyc <= cyc;
    if (frm_err) begin
      frm_cnt      <= frm_cnt + 1;
      frm_rise_cyc <= cyc;
    end
    busy_prev <= busy;
    rdy_prev  <= rdy;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rx(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed %0h expected <empty scoreboard>", tag, rx_data);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {24'h0, rx_data}, {24'h0, e});
    end
  endtask

  task automatic wait_rdy(input int limit);
    int n = 0;
    while (rdy !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_wait", {31'h0, rdy}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val, input int stop_bits);
    @(posedge clk); #1;
    RX = 1'b0;
    start_cyc = cyc;
    repeat (BD) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 RX = b[i];
      repeat (BD) @(posedge clk);
    end
    #1 RX = stop_val;
    repeat (BD * stop_bits) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr_rdy = 1'b1;
    @(posedge clk); #1 clr_rdy = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_data", {24'h0, rx_data}, 32'h0);
    chk("rst_rdy", {31'h0, rdy}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_frm_err", {31'h0, frm_err}, 32'd0);
    chk("rst_ovr_err", {31'h0, ovr_err}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Single byte with latency
    exp_q.push_back(8'h67);
    send_byte(8'h67, 1'b1, 1);
    chk("busy_latency", busy_rise_cyc - start_cyc, 32'd3);
    chk("rdy_latency", rdy_rise_cyc - start_cyc, LAT);
    chk("busy_fall_with_rdy", busy_fall_cyc, rdy_rise_cyc);
    check_rx("single_rx_data");
    chk("single_rdy", {31'h0, rdy}, 32'd1);
    chk("single_busy", {31'h0, busy}, 32'd0);
    chk("single_frm", frm_cnt, 32'd0);
    chk("single_ovr", {31'h0, ovr_err}, 32'd0);
    pulse_clr();
    chk("single_clr_rdy", {31'h0, rdy}, 32'd0);

    // Overrun
    exp_q.push_back(8'h67);
    send_byte(8'h67, 1'b1, 1);
    check_rx("ovr_first_rx_data");
    chk("ovr_first_ovr", {31'h0, ovr_err}, 32'd0);
    exp_q.push_back(8'h73);
    send_byte(8'h73, 1'b1, 1);
    check_rx("ovr_second_rx_data");
    chk("ovr_set", {31'h0, ovr_err}, 32'd1);
    chk("ovr_rdy", {31'h0, rdy}, 32'd1);
    pulse_clr();
    chk("ovr_clr_rdy", {31'h0, rdy}, 32'd0);
    chk("ovr_clr_ovr", {31'h0, ovr_err}, 32'd0);

    // clr_rdy on the exact commit cycle
    exp_q.push_back(8'h67);
    send_byte(8'h67, 1'b1, 1);
    check_rx("coinc_first_rx_data");
    exp_q.push_back(8'h73);
    fork
      send_byte(8'h73, 1'b1, 1);
      begin
        @(posedge clk);
        repeat (LAT - 1) @(posedge clk);
        #1 clr_rdy = 1'b1;
        @(posedge clk);
        #1 clr_rdy = 1'b0;
      end
    join
    check_rx("coinc_rx_data");
    chk("coinc_rdy", {31'h0, rdy}, 32'd1);
    chk("coinc_ovr", {31'h0, ovr_err}, 32'd0);
    pulse_clr();
    chk("coinc_clr_rdy", {31'h0, rdy}, 32'd0);

    // Framing error: stop bit held low for three bit times
    frm_base = frm_cnt;
    send_byte(8'h55, 1'b0, 3);
    chk("frm_busy_in_break", {31'h0, busy}, 32'd1);
    RX = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("frm_pulse_count", frm_cnt - frm_base, 32'd1);
    chk("frm_pulse_time", frm_rise_cyc - start_cyc, LAT);
    chk("frm_rdy", {31'h0, rdy}, 32'd0);
    chk("frm_rx_data_kept", {24'h0, rx_data}, 32'h73);
    chk("frm_busy_after", {31'h0, busy}, 32'd0);
    exp_q.push_back(8'h73);
    send_byte(8'h73, 1'b1, 1);
    check_rx("frm_next_rx_data");
    chk("frm_next_rdy", {31'h0, rdy}, 32'd1);
    chk("frm_next_no_frm", frm_cnt - frm_base, 32'd1);

    // Glitch shorter than half a bit (rdy left set from the previous byte)
    frm_base = frm_cnt;
    @(posedge clk); #1;
    RX = 1'b0;
    start_cyc = cyc;
    repeat (10) @(posedge clk);
    #1 RX = 1'b1;
    repeat (4 * BD) @(posedge clk);
    #1;
    chk("glitch_busy_rise", busy_rise_cyc - start_cyc, 32'd3);
    chk("glitch_busy_len", busy_fall_cyc - busy_rise_cyc, HD);
    chk("glitch_busy", {31'h0, busy}, 32'd0);
    chk("glitch_frm", frm_cnt - frm_base, 32'd0);
    chk("glitch_rx_data", {24'h0, rx_data}, 32'h73);
    chk("glitch_ovr", {31'h0, ovr_err}, 32'd0);

    // Reset mid-byte, with rdy and rx_data still holding the last byte
    @(posedge clk); #1;
    RX = 1'b0;
    repeat (BD) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 RX = a5[i];
      repeat (BD) @(posedge clk);
    end
    #1 RX = a5[4];
    repeat (HD) @(posedge clk);
    #3;
    chk("midrst_busy_before", {31'h0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rx_data", {24'h0, rx_data}, 32'h0);
    chk("midrst_rdy", {31'h0, rdy}, 32'd0);
    chk("midrst_busy", {31'h0, busy}, 32'd0);
    chk("midrst_frm", {31'h0, frm_err}, 32'd0);
    chk("midrst_ovr", {31'h0, ovr_err}, 32'd0);
    RX = 1'b1;
    #22 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    frm_base = frm_cnt;
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, 1);
    check_rx("postrst_rx_data");
    chk("postrst_rdy", {31'h0, rdy}, 32'd1);
    chk("postrst_ovr", {31'h0, ovr_err}, 32'd0);
    chk("postrst_frm", frm_cnt - frm_base, 32'd0);
    pulse_clr();

    // Back-to-back 0x00 then 0xFF
    fork
      begin
        exp_q.push_back(8'h00);
        send_byte(8'h00, 1'b1, 1);
        exp_q.push_back(8'hFF);
        send_byte(8'hFF, 1'b1, 1);
      end
      begin
        wait_rdy(2 * LAT);
        check_rx("b2b_first_rx_data");
        pulse_clr();
        wait_rdy(2 * LAT);
        check_rx("b2b_second_rx_data");
        chk("b2b_second_ovr", {31'h0, ovr_err}, 32'd0);
        pulse_clr();
      end
    join
    chk("b2b_frm", frm_cnt - frm_base, 32'd0);
    chk("b2b_rdy_cleared", {31'h0, rdy}, 32'd0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART 8N1 receiver.
- Takes the serial command stream from the BLE module (or the bench-side UART transmitter) on the RX pin and presents whole bytes to the authorization block through a ready/clear handshake.
- Reports framing and overrun errors.
- Sits between the RX pin and the Segway command/auth logic; its counterpart is the transmitter used to send 'g' (0x67) and 's' (0x73).

Parameters:
- BAUD_DIV, 2604, clocks per bit (50 MHz / 19200 baud); must be >= 16.
- HALF_DIV, BAUD_DIV/2, clocks from start-bit falling edge to mid-start-bit sample.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- RX  input  1  serial line; asynchronous to clk; idles high.
- clr_rdy  input  1  consumer acknowledge; clears rdy and ovr_err.
- rx_data  output  8  last correctly framed byte.
- rdy  output  1  byte available; held high until clr_rdy.
- busy  output  1  high whenever the FSM is not IDLE.
- frm_err  output  1  one-cycle pulse when the stop bit is sampled low.
- ovr_err  output  1  sticky; set when a byte completes while rdy is already high.

Behaviour:
- **Synchronizer:** RX passes through two flops, both preset to 1 on reset. A third registered copy gives falling-edge detect (prev=1, cur=0). All logic uses the synchronized value.
- **Reset values:** rx_data=0, rdy=0, busy=0, frm_err=0, ovr_err=0, FSM=IDLE, baud counter=0, bit counter=0, shift register=0. Reset is effective in any state; a partial byte is discarded and nothing is flagged.
- **Baud counter:** down-counter. A sample occurs on the cycle the counter reaches 0, and the counter is then reloaded with BAUD_DIV-1.
- **FSM states:**
  - IDLE: on synchronized falling edge, load HALF_DIV-1 and go to START.
  - START: at sample, if line=1 (glitch) go to IDLE with no flags; if line=0, load BAUD_DIV-1, bit count 0, go to DATA.
  - DATA: at each sample, shift the line into the MSB of the shift register (right shift, so bits arrive LSB first) and increment bit count. After the 8th sample go to STOP.
  - STOP: at sample, if line=1, commit the byte (see below) and go to IDLE. If line=0, pulse frm_err for 1 cycle, leave rx_data and rdy unchanged, and go to BREAK.
  - BREAK: wait until the synchronized line = 1, then go to IDLE. No new byte can start in BREAK.
- **Commit (registered, the cycle after the stop sample):**
  - rx_data <= shift register; rdy <= 1.
  - If rdy was already 1 and clr_rdy is not asserted that same cycle, ovr_err <= 1. The new byte still overwrites rx_data.
- **clr_rdy:**
  - Clears rdy and ovr_err on the next edge unless a commit occurs in the same cycle.
  - On a simultaneous commit and clr_rdy, the commit wins: rdy=1, ovr_err=0.
  - clr_rdy while rdy=0 has no effect.
- **Latency:**
  - rdy rises exactly 2 + HALF_DIV + 9*BAUD_DIV + 1 clocks after the RX pin falls; 24741 with defaults, ±1 for input sampling phase.
  - busy rises 3 clocks after the RX pin falls. busy falls together with rdy rising (or leaving BREAK).
- **Back-to-back bytes:** a falling edge on the first cycle back in IDLE is accepted. Because the stop sample is at mid-bit, there is half a bit of margin for the next start bit.
- **Width rules:** baud counter is $clog2(BAUD_DIV) bits; bit counter is 4 bits. There is no wrap-around in normal operation; counters are reloaded explicitly on every state entry.

Test Plan:
- **Single byte:** reset, then send 0x67 with a matching-baud transmitter → rdy rises 24741±1 clocks after the start edge; rx_data=8'h67; frm_err and ovr_err stay 0; busy low afterwards. Pulse clr_rdy → rdy=0 next cycle.
- **Overrun:** send 0x67, don't clear, send 0x73 → on the second commit ovr_err=1, rx_data=8'h73, rdy=1. clr_rdy → rdy=0, ovr_err=0. Repeat with clr_rdy asserted on the exact commit cycle → rdy=1, ovr_err=0.
- **Framing error:** drive start + 0x55 + stop=0 held for 3 bit times, then release → frm_err high for exactly 1 cycle at the stop sample, rdy=0, rx_data unchanged, busy stays high until the line returns high. A following 0x73 is received correctly.
- **Glitch rejection:** RX low for 500 clocks, then high → busy high for about 1302 clocks, then returns to IDLE; no rdy, no frm_err.
- **Reset mid-byte:** assert rst_n low after the 4th data bit of 0xA5 → all outputs 0 immediately (asynchronously). Release, send 0x3C → rx_data=8'h3C, rdy=1, no errors.
- **Back-to-back 0x00 then 0xFF** with 1-stop-bit spacing → both bytes committed in order (clr_rdy after each), no errors.
